// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default requester count and the grant record
// reused by output buffers and the ROB CDB port.
package cdb_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int CDB_IDX_W     = $clog2(N_REQ_DEFAULT);

    typedef struct packed {
        logic                 valid;
        logic [CDB_IDX_W-1:0] index;
    } cdb_grant_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// CDB arbitration bundle: requests/enable in, permit/grant/status out.
// master = arbiter side, slave = output-buffer / consumer side.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0] request;
    logic             bus_enable;
    logic [N_REQ-1:0] permit;
    logic             cdb_valid;
    logic [PTR_W-1:0] grant_index;
    logic [PTR_W-1:0] priority_ptr;
    logic [N_REQ-1:0] starved;

    modport master (
        input  request, bus_enable,
        output permit, cdb_valid, grant_index, priority_ptr, starved
    );

    modport slave (
        output request, bus_enable,
        input  permit, cdb_valid, grant_index, priority_ptr, starved
    );

endinterface

// File: rtl/cdb_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping, found by masking a doubled request vector and folding back.
module rr_priority_select
    import cdb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_request,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_index,
    output logic             o_valid
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_mask;
    logic [2*N_REQ-1:0] w_masked;
    logic               w_found;
    int                 w_pos;

    assign w_dbl    = {i_request, i_request};
    assign w_masked = w_dbl & w_mask;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        w_mask = '0;
        for (int j = 0; j < 2*N_REQ; j++) begin
            w_mask[j] = (j >= int'(i_ptr));
        end
    end

    // Descending scan: the last hit written is the lowest set bit.
    always_comb begin
        w_found = 1'b0;
        w_pos   = 0;
        for (int j = 2*N_REQ-1; j >= 0; j--) begin
            if (w_masked[j]) begin
                w_found = 1'b1;
                w_pos   = j;
            end
        end
    end

    always_comb begin
        o_valid = w_found;
        o_index = '0;
        o_grant = '0;
        if (w_found) begin
            o_index = PTR_W'((w_pos >= N_REQ) ? (w_pos - N_REQ) : w_pos);
            o_grant = N_REQ'(1) << o_index;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one grant per cycle, rotating priority pointer,
// per-requester wait counters with a starvation status flag.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int N_REQ        = N_REQ_DEFAULT,
    parameter  int WAIT_WIDTH   = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int PTR_W        = $clog2(N_REQ)
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.master bus
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_WIDTH-1:0] STARVE_TH = WAIT_WIDTH'(STARVE_LIMIT);

    logic [N_REQ-1:0]      w_req_eff;
    logic [N_REQ-1:0]      w_grant;
    logic [PTR_W-1:0]      w_index;
    logic                  w_valid;
    logic [PTR_W-1:0]      r_ptr;
    logic [WAIT_WIDTH-1:0] r_wait [N_REQ];

    // A blocked bus looks like no requests to the selector.
    assign w_req_eff = bus.request & {N_REQ{bus.bus_enable}};

    rr_priority_select #(
        .N_REQ (N_REQ)
    ) u_select (
        .i_request (w_req_eff),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_index   (w_index),
        .o_valid   (w_valid)
    );

    assign bus.permit       = w_grant;
    assign bus.cdb_valid    = w_valid;
    assign bus.grant_index  = w_index;
    assign bus.priority_ptr = r_ptr;

    always_comb begin
        bus.starved = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.starved[i] = (r_wait[i] >= STARVE_TH);
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples
    // pre-edge values. The counter array is only N_REQ small registers, so it
    // is reset like plain flops rather than treated as RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            if (w_valid) begin
                r_ptr <= (w_index == PTR_W'(N_REQ-1)) ? '0 : w_index + 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.request[i] || w_grant[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != WAIT_MAX) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB). Each functional-unit output buffer raises a request while it holds a result. The arbiter grants exactly one requester per cycle, drives the matching `data_bus_permit` and the bus-wide `cdb_valid`, and rotates priority so that no output buffer starves. It sits directly downstream of the functional-unit output buffers and upstream of every CDB consumer: reservation stations, reservation-station reset logic and the reorder buffer.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesting output buffers; must be ≥2.
- `WAIT_WIDTH`, default 4: width of the per-requester wait counters.
- `STARVE_LIMIT`, default 8: wait count at or above which a requester is flagged starved; must be < 2^WAIT_WIDTH.

Ports (clk, then reset):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `request`  in  N_REQ  bit i = output buffer i `not_empty`.
- `bus_enable`  in  1  0 = CDB blocked this cycle (e.g. ROB flush); no grant issued.
- `permit`  out  N_REQ  one-hot or zero; bit i drives buffer i `data_bus_permit`.
- `cdb_valid`  out  1  high iff `permit` is nonzero.
- `grant_index`  out  $clog2(N_REQ)  index of the granted requester; 0 when no grant.
- `priority_ptr`  out  $clog2(N_REQ)  current highest-priority requester index (debug).
- `starved`  out  N_REQ  bit i high while wait counter i ≥ STARVE_LIMIT.

## Operation
- Grant is combinational from `request`, `bus_enable` and the registered `priority_ptr`. The granted requester is the first set bit of `request`, scanning from `priority_ptr` upward with wrap at N_REQ.
- `bus_enable`=0 or `request`=0: `permit`=0, `cdb_valid`=0, `grant_index`=0.
- Pointer update at the edge: if a grant to i occurred, `priority_ptr` ← (i+1) mod N_REQ. With no grant it holds. The wrap from N_REQ-1 goes to 0.
- Wait counter i at the edge:
  - clears if `request[i]`=0 or i was granted;
  - otherwise increments, saturating at 2^WAIT_WIDTH−1.
- `starved` is decoded combinationally from the registered counters. It is status only and does not change the grant order.
- A request that drops in the same cycle is simply not considered. The arbiter assumes nothing about request stability.
- The output buffer pops on the same edge at which its permit is high, so a requester with more queued results re-requests on the next cycle at the lowest priority.

## Timing
- Zero-cycle grant latency: `permit` and `cdb_valid` are valid in the same cycle as `request`. Consumers (RS capture, RS reset) sample the CDB at the following edge.
- One CDB transfer per cycle maximum. With all N_REQ requesting continuously, each requester is granted exactly once every N_REQ cycles.
- Reset values: `priority_ptr`=0 and all wait counters 0. With `request`=0, outputs are `permit`=0, `cdb_valid`=0, `grant_index`=0 and `starved`=0.
- Reset mid-operation: when `reset` is high at an edge, the pointer and counters return to 0 regardless of a grant in that cycle. Combinational grants during the reset cycle are still computed from the current, pre-reset state.
- `bus_enable` low: the pointer holds, and the counters of requesting units increment.

## Structure
- Shared package `cdb_pkg`: the `N_REQ` default and the `cdb_grant_t` struct {valid, index}, reused by output buffers and the ROB CDB port.
- Sub-module `rr_priority_select` (combinational): takes request and pointer, produces the one-hot grant and its index. It is implemented by double-width masking: request concatenated with itself, masked below the pointer, first-one detect, folded back.
- Top level holds the pointer register, the wait counters and the starved decode.

## Test plan
- Reset, then `request`=0000 → `permit`=0000, `cdb_valid`=0, `priority_ptr`=0, `starved`=0000.
- `request`=1111 held 8 cycles → `grant_index` sequence 0,1,2,3,0,1,2,3; `priority_ptr` after each cycle is 1,2,3,0,…; `starved` stays 0.
- `priority_ptr`=3 and `request`=0110 → grant 1, pointer becomes 2. The next cycle `request`=0110 → grant 2, pointer becomes 3.
- `bus_enable`=0 for 9 cycles with `request`=0001 → `permit`=0 throughout, pointer unchanged, `starved[0]` rises on the 9th cycle (counter=8). Re-enable → grant 0, and `starved[0]` is 0 the cycle after.
- Reset asserted while `request`=1111 and pointer=2 → `permit`=0100 in that cycle; after the edge the pointer is 0, and the next grant is 0.
- Integration: output buffer holding tag 19 / data 41, plus one RS waiting on tag 19 → the arbiter grants, the CDB shows 41/19 with `cdb_valid`=1, and the RS and buffer both clear at the next edge.
